// File: rtl/clock_pkg.sv
// Shared definitions for the clock controller front end: key FSM state
// encoding, millisecond counter width, key index names and a saturating
// increment helper for the ms counters.
package clock_pkg;

    typedef enum logic [2:0] {
        KEY_IDLE     = 3'd0,
        KEY_PRESS_DB = 3'd1,
        KEY_HELD     = 3'd2,
        KEY_LONG     = 3'd3,
        KEY_REL_DB   = 3'd4
    } key_state_t;

    localparam int MS_CNT_W = 16;

    localparam int KEY_MODE  = 0;
    localparam int KEY_POS   = 1;
    localparam int KEY_INC   = 2;
    localparam int KEY_ALARM = 3;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [MS_CNT_W-1:0] ms_inc_sat(input logic [MS_CNT_W-1:0] v);
        return (v == {MS_CNT_W{1'b1}}) ? v : v + MS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/key_fsm.sv
// One key's conditioning path: 2-FF synchroniser, debounce / hold FSM,
// 1 ms counter and registered single-cycle event pulses.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat while in LONG).
// Without it o_repeat is tied low and the LONG-state counter is not built.
module key_fsm
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_n,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic       o_repeat,
    output logic [2:0] dbg_state
);

    localparam logic [MS_CNT_W-1:0] DB_CNT   = MS_CNT_W'(DEBOUNCE_MS);
    localparam logic [MS_CNT_W-1:0] LONG_CNT = MS_CNT_W'(LONG_MS);

    logic                sync1, sync2;
    logic                key;
    key_state_t          state, state_n;
    logic [MS_CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic                from_long, from_long_n;
    logic                press_n, release_n, long_n, repeat_n;
    logic                repeat_q;

    // Raw key is asynchronous; sync flops reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign key       = ~sync2;
    assign cnt_inc   = ms_inc_sat(cnt);
    assign dbg_state = state;

    // State, counter, origin flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= KEY_IDLE;
            cnt       <= '0;
            from_long <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            from_long <= from_long_n;
            o_press   <= press_n;
            o_release <= release_n;
            o_long    <= long_n;
            repeat_q  <= repeat_n;
        end
    end

    // Next-state and pulse decode; a released key always wins over a tick.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        from_long_n = from_long;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        repeat_n    = 1'b0;
        case (state)
            KEY_IDLE: begin
                if (key) begin
                    state_n = KEY_PRESS_DB;
                    cnt_n   = '0;
                end
            end
            KEY_PRESS_DB: begin
                if (!key) begin
                    state_n = KEY_IDLE;
                    cnt_n   = '0;
                end else if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_n = KEY_HELD;
                        cnt_n   = '0;
                        press_n = 1'b1;
                    end
                end
            end
            KEY_HELD: begin
                if (!key) begin
                    state_n     = KEY_REL_DB;
                    cnt_n       = '0;
                    from_long_n = 1'b0;
                end else if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == LONG_CNT) begin
                        state_n = KEY_LONG;
                        cnt_n   = '0;
                        long_n  = 1'b1;
                    end
                end
            end
            KEY_LONG: begin
                if (!key) begin
                    state_n     = KEY_REL_DB;
                    cnt_n       = '0;
                    from_long_n = 1'b1;
                end
`ifdef KEY_AUTO_REPEAT_EN
                else if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == MS_CNT_W'(REPEAT_MS)) begin
                        cnt_n    = '0;
                        repeat_n = 1'b1;
                    end
                end
`endif
            end
            KEY_REL_DB: begin
                if (key) begin
                    // Bounce back into the hold; the hold time starts over.
                    state_n = from_long ? KEY_LONG : KEY_HELD;
                    cnt_n   = '0;
                end else if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_n   = KEY_IDLE;
                        cnt_n     = '0;
                        release_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = KEY_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_cond.sv
// Push-button conditioner: shared 1 kHz prescaler plus one key_fsm per key.
// Outputs are clk-domain levels and single-cycle press / release / long /
// repeat events.
// Optional feature macro: KEY_AUTO_REPEAT_EN (o_repeat auto-repeat).
module key_cond
    import clock_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat
);

    localparam int DIV   = CLK_HZ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [2:0]       key_state [N_KEYS];

    assign tick = (pre_cnt == PRE_W'(DIV - 1));

    // Free-running 1 ms prescaler; tick marks the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_fsm #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_key_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .key_n     (i_key_n[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g]),
            .o_repeat  (o_repeat[g]),
            .dbg_state (key_state[g])
        );

        // Debounced level is high for every state after a confirmed press.
        assign o_level[g] = (key_state[g] == KEY_HELD) ||
                            (key_state[g] == KEY_LONG) ||
                            (key_state[g] == KEY_REL_DB);
    end

endmodule

// File: tb/tb_key_cond.sv
// Bench for key_cond. A tick every 100 clk keeps the run short while the
// ms-level timing (debounce 5, long 50, repeat 10) stays as intended.
// Expected pulse events are queued as stimulus is applied; a monitor pops
// and compares each pulse the DUT produces.
module tb_key_cond;

    localparam int N_KEYS  = 4;
    localparam int CLK_HZ  = 100000;
    localparam int DB_MS   = 5;
    localparam int LONG_MS = 50;
    localparam int REP_MS  = 10;
    localparam int MS      = CLK_HZ / 1000;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_KEYS-1:0] i_key_n;
    logic [N_KEYS-1:0] o_level, o_press, o_release, o_long, o_repeat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4:0]  exp_q[$];
    logic [4:0]  got_ev, want_ev;
    logic [15:0] prev_p = '0;

    key_cond #(
        .N_KEYS      (N_KEYS),
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DB_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REP_MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_n   (i_key_n),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_repeat  (o_repeat)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic pulse_bit(input int t, input int k);
        case (t)
            K_PRESS: return o_press[k];
            K_REL:   return o_release[k];
            K_LONG:  return o_long[k];
            default: return o_repeat[k];
        endcase
    endfunction

    function automatic logic [4:0] ev_code(input int t, input int k);
        return 5'(t * 4 + k);
    endfunction

    // Scoreboard monitor: every pulse must be the next expected event and 1 clk wide.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N_KEYS; k++) begin
                for (int t = 0; t < 4; t++) begin
                    if (pulse_bit(t, k)) begin
                        got_ev = ev_code(t, k);
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL sb_unexpected: got event kind=%0d key=%0d, required none (cyc %0d)", t, k, cyc);
                        end else begin
                            want_ev = exp_q.pop_front();
                            if (got_ev !== want_ev) begin
                                bad++;
                                $display("FAIL sb_order: got event %0d, required %0d (cyc %0d)", got_ev, want_ev, cyc);
                            end
                        end
                        total++;
                        if (prev_p[t*4+k] !== 1'b0) begin
                            bad++;
                            $display("FAIL pulse_width: kind=%0d key=%0d high 2 cycles, required 1", t, k);
                        end
                    end
                end
            end
        end
        prev_p <= {o_repeat, o_long, o_release, o_press};
    end

    // Global time limit.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ms(input int n);
        repeat (n * MS) @(posedge clk);
    endtask

    // Waits for a given pulse; at_cyc = -1 on timeout.
    task automatic wait_pulse(input int t, input int k, input int max_clk, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk);
            if (pulse_bit(t, k)) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [N_KEYS-1:0] acc;
        rst_n   = 1'b0;
        i_key_n = '1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (o_level !== '0)   begin bad++; $display("FAIL reset_level: got %b, required 0000", o_level); end
        total++; if (o_press !== '0)   begin bad++; $display("FAIL reset_press: got %b, required 0000", o_press); end
        total++; if (o_release !== '0) begin bad++; $display("FAIL reset_release: got %b, required 0000", o_release); end
        total++; if (o_long !== '0)    begin bad++; $display("FAIL reset_long: got %b, required 0000", o_long); end
        total++; if (o_repeat !== '0)  begin bad++; $display("FAIL reset_repeat: got %b, required 0000", o_repeat); end
        @(posedge clk);
        rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 100 * MS; i++) begin
            @(negedge clk);
            acc = acc | o_level;
        end
        total++; if (acc !== '0) begin bad++; $display("FAIL idle_level: got %b, required 0000", acc); end
    endtask

    task automatic test_bounce();
        int t_edge, at;
        exp_q.push_back(ev_code(K_PRESS, 0));
        for (int i = 0; i < 10; i++) begin
            i_key_n[0] = i[0];
            wait_ms(2);
        end
        i_key_n[0] = 1'b0;
        t_edge = cyc;
        wait_pulse(K_PRESS, 0, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL bounce_press: got timeout, required press"); end
        else if (at - t_edge < 4 * MS || at - t_edge > 6 * MS) begin
            bad++; $display("FAIL bounce_latency: got %0d clk, required %0d..%0d", at - t_edge, 4 * MS, 6 * MS);
        end
        total++; if (o_level[0] !== 1'b1) begin bad++; $display("FAIL bounce_level: got %b, required 1", o_level[0]); end
        exp_q.push_back(ev_code(K_REL, 0));
        @(posedge clk);
        i_key_n[0] = 1'b1;
        t_edge = cyc;
        wait_pulse(K_REL, 0, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL bounce_release: got timeout, required release"); end
        else if (at - t_edge < 4 * MS || at - t_edge > 6 * MS) begin
            bad++; $display("FAIL release_latency: got %0d clk, required %0d..%0d", at - t_edge, 4 * MS, 6 * MS);
        end
        total++; if (o_level[0] !== 1'b0) begin bad++; $display("FAIL release_level: got %b, required 0", o_level[0]); end
    endtask

    task automatic test_glitch();
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        i_key_n[1] = 1'b0;
        for (int i = 0; i < 3 * MS; i++) begin
            @(negedge clk);
            acc = acc | o_level[1];
        end
        i_key_n[1] = 1'b1;
        for (int i = 0; i < 20 * MS; i++) begin
            @(negedge clk);
            acc = acc | o_level[1];
        end
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL glitch_level: got %b, required 0", acc); end
    endtask

    task automatic test_long_hold();
        int t_start, t_press, t_long, t_edge, at;
        logic rep_acc;
`ifdef KEY_AUTO_REPEAT_EN
        int t_rep;
`endif
        exp_q.push_back(ev_code(K_PRESS, 2));
        exp_q.push_back(ev_code(K_LONG, 2));
`ifdef KEY_AUTO_REPEAT_EN
        exp_q.push_back(ev_code(K_REP, 2));
        exp_q.push_back(ev_code(K_REP, 2));
`endif
        exp_q.push_back(ev_code(K_REL, 2));
        @(posedge clk);
        i_key_n[2] = 1'b0;
        t_start = cyc;
        wait_pulse(K_PRESS, 2, 10 * MS, t_press);
        total++;
        if (t_press < 0) begin bad++; $display("FAIL long_press: got timeout, required press"); end
        else if (t_press - t_start < 4 * MS || t_press - t_start > 6 * MS) begin
            bad++; $display("FAIL long_press_latency: got %0d clk, required %0d..%0d", t_press - t_start, 4 * MS, 6 * MS);
        end
        wait_pulse(K_LONG, 2, 60 * MS, t_long);
        total++;
        if (t_long < 0) begin bad++; $display("FAIL long_pulse: got timeout, required o_long"); end
        else if (t_long - t_press != LONG_MS * MS) begin
            bad++; $display("FAIL long_delay: got %0d clk after press, required %0d", t_long - t_press, LONG_MS * MS);
        end
        total++; if (o_press[2] !== 1'b0) begin bad++; $display("FAIL long_vs_press: got o_press=%b with o_long, required 0", o_press[2]); end
`ifdef KEY_AUTO_REPEAT_EN
        for (int r = 0; r < 2; r++) begin
            wait_pulse(K_REP, 2, 15 * MS, t_rep);
            total++;
            if (t_rep < 0) begin bad++; $display("FAIL repeat_%0d: got timeout, required o_repeat", r); end
            else if (t_rep - t_long != REP_MS * MS) begin
                bad++; $display("FAIL repeat_delay_%0d: got %0d clk, required %0d", r, t_rep - t_long, REP_MS * MS);
            end
            t_long = t_rep;
        end
`endif
        rep_acc = 1'b0;
        for (int i = 0; i < 100 * MS && (cyc - t_start) < 80 * MS; i++) begin
            @(negedge clk);
            rep_acc = rep_acc | o_repeat[2];
        end
`ifndef KEY_AUTO_REPEAT_EN
        total++; if (rep_acc !== 1'b0) begin bad++; $display("FAIL repeat_off: got %b, required 0", rep_acc); end
`endif
        total++; if (o_level[2] !== 1'b1) begin bad++; $display("FAIL long_level: got %b, required 1", o_level[2]); end
        @(posedge clk);
        i_key_n[2] = 1'b1;
        t_edge = cyc;
        wait_pulse(K_REL, 2, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL long_release: got timeout, required release"); end
        else if (at - t_edge < 4 * MS || at - t_edge > 6 * MS) begin
            bad++; $display("FAIL long_release_latency: got %0d clk, required %0d..%0d", at - t_edge, 4 * MS, 6 * MS);
        end
    endtask

    task automatic test_simultaneous();
        int at;
        exp_q.push_back(ev_code(K_PRESS, 0));
        exp_q.push_back(ev_code(K_PRESS, 3));
        @(posedge clk);
        i_key_n = 4'b0110;
        wait_pulse(K_PRESS, 0, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL simul_press0: got timeout, required press"); end
        else if (o_press[3] !== 1'b1) begin bad++; $display("FAIL simul_press3: got %b, required 1 same cycle", o_press[3]); end
        exp_q.push_back(ev_code(K_REL, 0));
        exp_q.push_back(ev_code(K_REL, 3));
        @(posedge clk);
        i_key_n = 4'b1111;
        wait_pulse(K_REL, 0, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL simul_rel0: got timeout, required release"); end
        else if (o_release[3] !== 1'b1) begin bad++; $display("FAIL simul_rel3: got %b, required 1 same cycle", o_release[3]); end
        wait_ms(2);
    endtask

    task automatic test_reset_mid_hold();
        int t_start, t_edge, at;
        exp_q.push_back(ev_code(K_PRESS, 3));
        @(posedge clk);
        i_key_n[3] = 1'b0;
        t_start = cyc;
        wait_pulse(K_PRESS, 3, 10 * MS, at);
        total++; if (at < 0) begin bad++; $display("FAIL mid_press: got timeout, required press"); end
        while ((cyc - t_start) < 30 * MS) @(negedge clk);
        total++; if (o_level[3] !== 1'b1) begin bad++; $display("FAIL mid_level_before: got %b, required 1", o_level[3]); end
        rst_n = 1'b0;
        #1;
        total++; if (o_level !== '0) begin bad++; $display("FAIL mid_reset_level: got %b, required 0000", o_level); end
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        t_edge = cyc;
        exp_q.push_back(ev_code(K_PRESS, 3));
        wait_pulse(K_PRESS, 3, 10 * MS, at);
        total++;
        if (at < 0) begin bad++; $display("FAIL mid_repress: got timeout, required fresh press"); end
        else if (at - t_edge < 4 * MS || at - t_edge > 6 * MS) begin
            bad++; $display("FAIL mid_repress_latency: got %0d clk, required %0d..%0d", at - t_edge, 4 * MS, 6 * MS);
        end
        exp_q.push_back(ev_code(K_REL, 3));
        @(posedge clk);
        i_key_n[3] = 1'b1;
        wait_pulse(K_REL, 3, 10 * MS, at);
        total++; if (at < 0) begin bad++; $display("FAIL mid_release: got timeout, required release"); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_long_hold();
        test_simultaneous();
        test_reset_mid_hold();
        wait_ms(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending events, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
